// File: rtl/datapath_sequencer.sv
// datapath_sequencer: IDLE/LOAD_A/LOAD_B/EXEC/WRITE_IMM|WRITE_C/DONE control for regfile+shifter+ALU; in: clk reset_n instr_in imm_in instr_valid [step if SEQ_SINGLE_STEP_EN]; out: instr_ready readnum loada loadb shift asel bsel ALUop loadc loads write writenum vsel datapath_in busy done retired
module datapath_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      instr_in,
  input  logic [7:0]       imm_in,
  input  logic             instr_valid,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic             instr_ready,
  output logic [2:0]       readnum,
  output logic             loada,
  output logic             loadb,
  output logic [1:0]       shift,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       ALUop,
  output logic             loadc,
  output logic             loads,
  output logic             write,
  output logic [2:0]       writenum,
  output logic             vsel,
  output logic [15:0]      datapath_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, WRITE_IMM, WRITE_C, DONE} state_t;
  localparam logic [1:0] K_MOVI = 2'b00, K_MOVR = 2'b10, K_CMP = 2'b11;
  state_t state, next;
  logic [15:1] ir;
  logic [7:0] imm;
  logic adv, ex;
  logic [1:0] kind;
  logic unused_bit0;
  assign unused_bit0 = instr_in[0];
  assign kind = ir[15:14];
  assign ex = state == EXEC;
`ifdef SEQ_SINGLE_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ir      <= '0;
      imm     <= '0;
      retired <= '0;
    end else begin
      if (instr_valid && instr_ready) begin
        ir  <= instr_in[15:1];
        imm <= imm_in;
      end
      if (state == DONE && adv) retired <= retired + CNT_W'(1);
    end
  always_comb begin
    next = state;
    case (state)
      IDLE:      if (instr_valid) next = instr_in[15:14] == K_MOVI ? WRITE_IMM :
                                         instr_in[15:14] == K_MOVR ? LOAD_B : LOAD_A;
      LOAD_A:    if (adv) next = LOAD_B;
      LOAD_B:    if (adv) next = EXEC;
      EXEC:      if (adv) next = kind == K_CMP ? DONE : WRITE_C;
      WRITE_IMM: if (adv) next = DONE;
      WRITE_C:   if (adv) next = DONE;
      DONE:      if (adv) next = IDLE;
      default:   next = IDLE;
    endcase
  end
  always_comb begin
    instr_ready = state == IDLE;
    busy        = state != IDLE;
    done        = state == DONE;
    loada       = state == LOAD_A;
    loadb       = state == LOAD_B;
    readnum     = loada ? ir[8:6] : loadb ? ir[5:3] : 3'd0;
    shift       = ex ? ir[2:1] : 2'b00;
    asel        = ex && kind == K_MOVR;
    bsel        = 1'b0;
    ALUop       = !ex ? 2'b00 : kind == K_CMP ? 2'b01 : kind == K_MOVR ? 2'b00 : ir[13:12];
    loadc       = ex && kind != K_CMP;
    loads       = ex && kind == K_CMP;
    write       = state == WRITE_IMM || state == WRITE_C;
    writenum    = write ? ir[11:9] : 3'd0;
    vsel        = state == WRITE_IMM;
    datapath_in = {8'h00, imm};
  end
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: table-driven and sequence checks for datapath_sequencer
module tb_datapath_sequencer;
  logic clk = 1'b0, reset_n = 1'b0, instr_valid = 1'b0, step = 1'b1;
  logic [15:0] instr_in = '0;
  logic [7:0] imm_in = '0;
  logic instr_ready, loada, loadb, asel, bsel, loadc, loads, write, vsel, busy, done;
  logic [2:0] readnum, writenum;
  logic [1:0] shift, ALUop;
  logic [15:0] datapath_in;
  logic [7:0] retired;
  logic w2_ready, w2_la, w2_lb, w2_as, w2_bs, w2_lc, w2_ls, w2_wr, w2_vs, w2_busy, w2_done;
  logic [2:0] w2_rn, w2_wn;
  logic [1:0] w2_sh, w2_op, retired2;
  logic [15:0] w2_din;
  int errors = 0, checks = 0, exp_ret = 0;
  always #5 clk = ~clk;
  datapath_sequencer dut (
    .clk(clk), .reset_n(reset_n), .instr_in(instr_in), .imm_in(imm_in), .instr_valid(instr_valid),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .instr_ready(instr_ready), .readnum(readnum), .loada(loada), .loadb(loadb), .shift(shift),
    .asel(asel), .bsel(bsel), .ALUop(ALUop), .loadc(loadc), .loads(loads), .write(write),
    .writenum(writenum), .vsel(vsel), .datapath_in(datapath_in), .busy(busy), .done(done),
    .retired(retired)
  );
  datapath_sequencer #(.CNT_W(2)) u_w2 (
    .clk(clk), .reset_n(reset_n), .instr_in(instr_in), .imm_in(imm_in), .instr_valid(instr_valid),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .instr_ready(w2_ready), .readnum(w2_rn), .loada(w2_la), .loadb(w2_lb), .shift(w2_sh),
    .asel(w2_as), .bsel(w2_bs), .ALUop(w2_op), .loadc(w2_lc), .loads(w2_ls), .write(w2_wr),
    .writenum(w2_wn), .vsel(w2_vs), .datapath_in(w2_din), .busy(w2_busy), .done(w2_done),
    .retired(retired2)
  );
  typedef struct {
    logic [15:0]      instr;
    logic [7:0]       imm;
    int               n;
    logic [4:0][20:0] exp;
  } vec_t;
  vec_t tbl[6];
  localparam logic [20:0] IDLE_W = {2'b01, 19'd0};
  function automatic logic [20:0] cw(input logic [2:0] rn, input logic la, input logic lb,
                                     input logic [1:0] sh, input logic as, input logic [1:0] op,
                                     input logic lc, input logic ls, input logic wr,
                                     input logic [2:0] wn, input logic vs, input logic dn);
    return {2'b10, rn, la, lb, sh, as, 1'b0, op, lc, ls, wr, wn, vs, dn};
  endfunction
  function automatic logic [20:0] obs();
    return {busy, instr_ready, readnum, loada, loadb, shift, asel, bsel, ALUop,
            loadc, loads, write, writenum, vsel, done};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v, input string nm);
    @(negedge clk);
    instr_in = v.instr;
    imm_in = v.imm;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_in = ~v.instr;
    imm_in = ~v.imm;
    chk({nm, " datapath_in"}, 32'(datapath_in), {16'h0, 8'h00, v.imm});
    for (int i = 0; i < v.n; i++) begin
      chk($sformatf("%s cycle %0d", nm, i + 1), 32'(obs()), 32'(v.exp[i]));
      @(posedge clk);
      #1;
    end
    exp_ret++;
    chk({nm, " idle after"}, 32'(obs()), 32'(IDLE_W));
    chk({nm, " retired"}, 32'(retired), 32'(exp_ret[7:0]));
    chk({nm, " retired w2"}, 32'(retired2), 32'(exp_ret[1:0]));
  endtask
  initial begin
    logic [20:0] dn;
    logic [15:0] mv[3];
    int acc[3];
    int k, dones, asels;
    logic rdy;
    dn = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[0].instr = 16'h0600; tbl[0].imm = 8'h5A; tbl[0].n = 2;
    tbl[0].exp[0] = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0); tbl[0].exp[1] = dn;
    tbl[1].instr = 16'h4A88; tbl[1].imm = 8'h11; tbl[1].n = 5;
    tbl[1].exp[0] = cw(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1].exp[1] = cw(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1].exp[2] = cw(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1].exp[3] = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0); tbl[1].exp[4] = dn;
    tbl[2].instr = 16'hEF32; tbl[2].imm = 8'h22; tbl[2].n = 4;
    tbl[2].exp[0] = cw(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2].exp[1] = cw(6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2].exp[2] = cw(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0); tbl[2].exp[3] = dn;
    tbl[3].instr = 16'hB3DD; tbl[3].imm = 8'h33; tbl[3].n = 4;
    tbl[3].exp[0] = cw(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3].exp[1] = cw(0, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0);
    tbl[3].exp[2] = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); tbl[3].exp[3] = dn;
    tbl[4].instr = 16'h71EE; tbl[4].imm = 8'h44; tbl[4].n = 5;
    tbl[4].exp[0] = cw(7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4].exp[1] = cw(5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4].exp[2] = cw(0, 0, 0, 3, 0, 3, 1, 0, 0, 0, 0, 0);
    tbl[4].exp[3] = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); tbl[4].exp[4] = dn;
    tbl[5].instr = 16'h1E00; tbl[5].imm = 8'hFF; tbl[5].n = 2;
    tbl[5].exp[0] = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0); tbl[5].exp[1] = dn;
    mv[0] = 16'hB3DD; mv[1] = 16'h8000; mv[2] = 16'h8E2A;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", 32'(obs()), 32'(IDLE_W));
    chk("reset datapath_in", 32'(datapath_in), 32'h0);
    chk("reset retired", 32'(retired), 32'h0);
    chk("reset retired w2", 32'(retired2), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    instr_in = 16'h4A88;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    for (int i = 0; i < 10 && !write; i++) begin
      @(posedge clk);
      #1;
    end
    chk("reach WRITE_C", 32'({write, writenum}), 32'({1'b1, 3'd5}));
    #2 reset_n = 1'b0;
    #1;
    chk("async reset write", 32'({write, loads}), 32'h0);
    chk("async reset outputs", 32'(obs()), 32'(IDLE_W));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post reset idle", 32'(obs()), 32'(IDLE_W));
    chk("post reset retired", 32'(retired), 32'h0);
    for (int i = 0; i < 5; i++) run_vec(tbl[0], $sformatf("movi wrap %0d", i));
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec %0d", i));
    instr_valid = 1'b1;
    instr_in = mv[0];
    k = 0; dones = 0; asels = 0;
    for (int c = 0; c < 60 && dones < 3; c++) begin
      @(negedge clk);
      dones += int'(done);
      asels += int'(asel);
      rdy = instr_ready;
      @(posedge clk);
      #1;
      if (rdy && k < 3) begin
        acc[k] = c;
        k++;
        if (k < 3) instr_in = mv[k];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    exp_ret += 3;
    chk("b2b accepts", 32'(k), 32'd3);
    chk("b2b done pulses", 32'(dones), 32'd3);
    chk("b2b asel cycles", 32'(asels), 32'd3);
    chk("b2b spacing 1", 32'(acc[1] - acc[0]), 32'd5);
    chk("b2b spacing 2", 32'(acc[2] - acc[1]), 32'd5);
    chk("b2b retired", 32'(retired), 32'(exp_ret[7:0]));
    chk("b2b retired w2", 32'(retired2), 32'(exp_ret[1:0]));
`ifdef SEQ_SINGLE_STEP_EN
    @(negedge clk);
    step = 1'b0;
    instr_in = 16'h4A88;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("step hold LOAD_A %0d", i), 32'(obs()), 32'(tbl[1].exp[0]));
      @(posedge clk);
      #1;
    end
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      step = 1'b1;
      @(posedge clk);
      #1;
      step = 1'b0;
      chk($sformatf("step pulse %0d", p + 1), 32'(obs()), 32'(tbl[1].exp[p + 1]));
    end
    @(posedge clk);
    #1;
    chk("step hold DONE", 32'(obs()), 32'(dn));
    chk("step retired held", 32'(retired), 32'(exp_ret[7:0]));
    @(negedge clk);
    step = 1'b1;
    @(posedge clk);
    #1;
    exp_ret++;
    chk("step leave DONE", 32'(obs()), 32'(IDLE_W));
    chk("step retired", 32'(retired), 32'(exp_ret[7:0]));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle controller that sequences the register-file / shifter / ALU datapath through its three stages: register read, execute, writeback.
- Accepts one 16-bit instruction per valid/ready handshake and drives every datapath control input: readnum, loada, loadb, shift, asel, bsel, ALUop, loadc, loads, write, writenum, vsel.
- Replaces manual switch-driven control. Sits between an instruction source and the datapath.

Parameters:
- CNT_W, 8, width of the retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- instr_in  input  16  instruction; sampled on accept
- imm_in  input  8  immediate for MOVI; sampled on accept
- instr_valid  input  1  source has an instruction
- instr_ready  output  1  sequencer can accept
- readnum  output  3  register read address
- loada, loadb  output  1 each  A/B register loads
- shift  output  2  shifter control
- asel  output  1  1 = A operand forced to 0
- bsel  output  1  always 0
- ALUop  output  2  ALU operation
- loadc, loads  output  1 each  C/status register loads
- write  output  1  register-file write enable
- writenum  output  3  register write address
- vsel  output  1  1 = write datapath_in, 0 = write C
- datapath_in  output  16  {8'b0, latched imm}
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on completion
- retired  output  CNT_W  count of completed instructions

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on reset_n.
- Instruction encoding:
  - [15:14] kind: 00 MOVI, 01 ALU, 10 MOVR, 11 CMP
  - [13:12] ALUop
  - [11:9] Rd
  - [8:6] Rn
  - [5:3] Rm
  - [2:1] shift
  - [0] ignored
- Handshake:
  - instr_ready = 1 only in IDLE.
  - Accept on a rising edge with instr_valid & instr_ready. instr_in and imm_in latch into internal registers on that edge.
  - instr_valid while busy is ignored and not queued.
- States: IDLE, LOAD_A, LOAD_B, EXEC, WRITE_IMM, WRITE_C, DONE.
- Transitions from IDLE on accept:
  - MOVI -> WRITE_IMM
  - ALU, CMP -> LOAD_A
  - MOVR -> LOAD_B
- Onward transitions:
  - LOAD_A -> LOAD_B -> EXEC
  - EXEC -> WRITE_C for ALU/MOVR; EXEC -> DONE for CMP
  - WRITE_IMM, WRITE_C -> DONE
  - DONE -> IDLE unconditionally
- Per-state outputs (anything not listed is 0):
  - LOAD_A: readnum = Rn, loada = 1
  - LOAD_B: readnum = Rm, loadb = 1
  - EXEC, ALU: shift = field, ALUop = field, loadc = 1
  - EXEC, MOVR: shift = field, asel = 1, ALUop = 00, loadc = 1
  - EXEC, CMP: shift = field, ALUop = 01, loads = 1, loadc = 0
  - WRITE_IMM: write = 1, vsel = 1, writenum = Rd
  - WRITE_C: write = 1, vsel = 0, writenum = Rd
  - DONE: done = 1; retired increments on the same edge that leaves DONE
- Output timing: all outputs are decoded from the state register and latched instruction only. No combinational path exists from instr_valid, instr_in or imm_in to any output. datapath_in always reflects the latched immediate.
- Latency, counted from the accept edge to the first cycle with done = 1:
  - MOVI: 2 cycles
  - MOVR: 4 cycles
  - CMP: 4 cycles
  - ALU: 5 cycles
- Throughput: one idle cycle between instructions. Back-to-back instr_valid held high is accepted in the cycle after DONE.
- Reset values: state IDLE, latched instruction and immediate 0, retired 0, instr_ready 1, all other outputs 0.
- Reset mid-instruction: write and loads drop immediately (asynchronously). The partial instruction is abandoned and not counted.
- Counter wrap: retired rolls from 2^CNT_W-1 to 0 with no flag.

Optional Feature:
- SEQ_SINGLE_STEP_EN
- Defined:
  - Adds input step (1 bit, synchronous, already debounced).
  - Every transition out of a non-IDLE state happens only on an edge where step = 1. The state and its outputs are held otherwise, so a held write repeats the same write.
  - Acceptance from IDLE is unaffected by step.
- Undefined: step port is absent and states advance every cycle.

Test Plan:
- Reset, then MOVI R3 with imm 0x5A -> one cycle with write=1, vsel=1, writenum=3, datapath_in=0x005A; done pulses 2 cycles after accept; retired=1.
- ALU instr 0x4A88 (ALUop 00, Rd 5, Rn 2, Rm 1, shift 00) -> LOAD_A readnum=2/loada; LOAD_B readnum=1/loadb; EXEC loadc=1, ALUop=00; WRITE_C writenum=5, vsel=0; done at +5.
- CMP with Rn=4, Rm=6, shift=01 -> EXEC shows loads=1, ALUop=01, shift=01, loadc=0; write never asserted; done at +4.
- instr_valid held high with 3 MOVR instructions queued by the source -> each accepted only when instr_ready=1; exactly 3 done pulses; retired=3; ALU-stage asel=1 every time.
- Assert reset_n low during WRITE_C -> write falls without waiting for clk; after release: IDLE, instr_ready=1, retired unchanged.
- CNT_W=2, run 5 MOVIs -> retired reads 1,2,3,0,1. With SEQ_SINGLE_STEP_EN: ALU instruction with no step pulses stays in LOAD_A indefinitely; 4 step pulses reach DONE.
